// File: rtl/nn_ve_cmd_dispatcher.sv
// rtl/nn_ve_cmd_dispatcher.sv - NN-side VE command dispatcher: ID tagging, issue buffer, outstanding tracking
module nn_ve_cmd_dispatcher #(
  parameter int CMD_ID_W        = 4,
  parameter int CMD_W           = 64,
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 nn_cmd_vld_i,
  output logic                                 nn_cmd_rdy_o,
  input  logic [CMD_W-1:0]                     nn_cmd_data_i,
  output logic                                 nn_ve_cmd_ds_vld_o,
  input  logic                                 nn_ve_cmd_ds_rdy_i,
  output logic [CMD_ID_W-1:0]                  nn_ve_cmd_ds_id_o,
  output logic [CMD_W-1:0]                     nn_ve_cmd_ds_data_o,
  input  logic                                 nn_ve_cmd_done_i,
  input  logic [CMD_ID_W-1:0]                  nn_ve_cmd_id_done_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
  output logic                                 idle_o,
  output logic                                 err_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);
  localparam logic [OUT_W-1:0] OUT_MAX  = OUT_W'(MAX_OUTSTANDING);

  logic [CMD_ID_W-1:0] id_mem   [FIFO_DEPTH];
  logic [CMD_W-1:0]    data_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [OCC_W-1:0]    occ;
  logic [OUT_W-1:0]    outstanding;
  logic [CMD_ID_W-1:0] alloc_id;
  logic [CMD_ID_W-1:0] exp_id;
  logic                rdy_en;
  logic                err;
  logic                push;
  logic                pop;
  logic                fifo_empty;
  logic                done_ok;
  logic                done_bad;

  // rdy_en keeps the upstream ready low for the cycle a reset is applied
  assign fifo_empty          = (occ == '0);
  assign nn_cmd_rdy_o        = rdy_en & (occ < OCC_FULL);
  assign nn_ve_cmd_ds_vld_o  = ~fifo_empty & (outstanding < OUT_MAX);
  assign nn_ve_cmd_ds_id_o   = fifo_empty ? '0 : id_mem[rd_ptr];
  assign nn_ve_cmd_ds_data_o = fifo_empty ? '0 : data_mem[rd_ptr];
  assign outstanding_o       = outstanding;
  assign idle_o              = fifo_empty & (outstanding == '0);
  assign err_o               = err;

  assign push = nn_cmd_vld_i & nn_cmd_rdy_o;
  assign pop  = nn_ve_cmd_ds_vld_o & nn_ve_cmd_ds_rdy_i;

  // A done with nothing registered as outstanding is spurious, even alongside an issue
  assign done_ok  = nn_ve_cmd_done_i & (outstanding != '0);
  assign done_bad = nn_ve_cmd_done_i &
                    ((outstanding == '0) | (nn_ve_cmd_id_done_i != exp_id));

  always_ff @(posedge clk) begin
    if (push) begin
      id_mem[wr_ptr]   <= alloc_id;
      data_mem[wr_ptr] <= nn_cmd_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      occ         <= '0;
      outstanding <= '0;
      alloc_id    <= '0;
      exp_id      <= '0;
      rdy_en      <= 1'b0;
      err         <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (push) begin
        wr_ptr   <= wr_ptr + PTR_W'(1);
        alloc_id <= alloc_id + CMD_ID_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
      case ({pop, done_ok})
        2'b10:   outstanding <= outstanding + OUT_W'(1);
        2'b01:   outstanding <= outstanding - OUT_W'(1);
        default: outstanding <= outstanding;
      endcase
      if (done_ok) begin
        exp_id <= exp_id + CMD_ID_W'(1);
      end
      if (done_bad) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_nn_ve_cmd_dispatcher.sv
// tb/tb_nn_ve_cmd_dispatcher.sv - scoreboard bench for nn_ve_cmd_dispatcher
module tb_nn_ve_cmd_dispatcher;

  localparam int IDW = 4;
  localparam int DW  = 64;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           nn_cmd_vld_i;
  logic           nn_cmd_rdy_o;
  logic [DW-1:0]  nn_cmd_data_i;
  logic           ds_vld;
  logic           ds_rdy = 1'b1;
  logic [IDW-1:0] ds_id;
  logic [DW-1:0]  ds_data;
  logic           done_i;
  logic [IDW-1:0] id_done;
  logic [3:0]     outstanding;
  logic           idle;
  logic           err;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [DW-1:0]  data;
  } exp_t;

  exp_t           exp_q[$];
  logic [DW-1:0]  send_q[$];
  logic [IDW-1:0] done_q[$];
  int             pass_cnt = 0;
  int             total_cnt = 0;
  int             issue_cnt = 0;
  int             accept_cnt = 0;
  bit             auto_done = 1'b0;
  logic [IDW-1:0] tb_alloc = '0;

  always #5 clk = ~clk;

  nn_ve_cmd_dispatcher #(
    .CMD_ID_W(IDW), .CMD_W(DW), .FIFO_DEPTH(4), .MAX_OUTSTANDING(8)
  ) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .nn_cmd_vld_i        (nn_cmd_vld_i),
    .nn_cmd_rdy_o        (nn_cmd_rdy_o),
    .nn_cmd_data_i       (nn_cmd_data_i),
    .nn_ve_cmd_ds_vld_o  (ds_vld),
    .nn_ve_cmd_ds_rdy_i  (ds_rdy),
    .nn_ve_cmd_ds_id_o   (ds_id),
    .nn_ve_cmd_ds_data_o (ds_data),
    .nn_ve_cmd_done_i    (done_i),
    .nn_ve_cmd_id_done_i (id_done),
    .outstanding_o       (outstanding),
    .idle_o              (idle),
    .err_o               (err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Upstream driver: presents send_q head, books the expected issue on each accept
  initial begin
    nn_cmd_vld_i  = 1'b0;
    nn_cmd_data_i = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        send_q.delete();
        exp_q.delete();
        tb_alloc   = '0;
        accept_cnt = 0;
      end else if (nn_cmd_vld_i && nn_cmd_rdy_o) begin
        exp_q.push_back('{id: tb_alloc, data: nn_cmd_data_i});
        tb_alloc++;
        accept_cnt++;
        void'(send_q.pop_front());
      end
      @(posedge clk);
      #1;
      if (send_q.size() > 0) begin
        nn_cmd_vld_i  = 1'b1;
        nn_cmd_data_i = send_q[0];
      end else begin
        nn_cmd_vld_i  = 1'b0;
        nn_cmd_data_i = '0;
      end
    end
  end

  // Monitor: every issue handshake is compared against the scoreboard head
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        done_q.delete();
      end else if (ds_vld && ds_rdy) begin
        issue_cnt++;
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_issue: got issue id %0d, required no issue at %0t", ds_id, $time);
        end else begin
          e = exp_q.pop_front();
          check("issue_id", 64'(ds_id), 64'(e.id));
          check("issue_data", ds_data, e.data);
        end
        if (auto_done) done_q.push_back(ds_id);
      end
    end
  end

  // VE completion responder: one done pulse per queued id
  initial begin
    done_i  = 1'b0;
    id_done = '0;
    forever begin
      @(posedge clk);
      #1;
      if (reset_n && done_q.size() > 0) begin
        done_i  = 1'b1;
        id_done = done_q.pop_front();
      end else begin
        done_i = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish before 100000");
    $fatal(1);
  end

  task automatic do_reset();
    @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic set_ds_rdy(input logic v);
    @(posedge clk);
    #1 ds_rdy = v;
  endtask

  task automatic check_reset_values(input logic exp_rdy);
    check("rst_cmd_rdy", 64'(nn_cmd_rdy_o), 64'(exp_rdy));
    check("rst_ds_vld", 64'(ds_vld), 0);
    check("rst_ds_id", 64'(ds_id), 0);
    check("rst_ds_data", ds_data, 0);
    check("rst_outstanding", 64'(outstanding), 0);
    check("rst_idle", 64'(idle), 1);
    check("rst_err", 64'(err), 0);
  endtask

  initial begin
    int base;
    bit seen;

    // Power-on reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values(1'b0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rdy_after_reset", 64'(nn_cmd_rdy_o), 1);

    // Single command
    send_q.push_back(64'hA5);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (nn_cmd_vld_i && nn_cmd_rdy_o) seen = 1'b1;
    end
    check("single_accepted", 64'(seen), 1);
    @(negedge clk);
    check("single_vld_lat1", 64'(ds_vld), 1);
    check("single_id", 64'(ds_id), 0);
    check("single_data", ds_data, 64'hA5);
    @(negedge clk);
    check("single_outstanding", 64'(outstanding), 1);
    check("single_idle_low", 64'(idle), 0);
    done_q.push_back(4'd0);
    repeat (4) @(negedge clk);
    check("single_done_outstanding", 64'(outstanding), 0);
    check("single_done_idle", 64'(idle), 1);
    check("single_done_err", 64'(err), 0);

    // Back-pressure
    do_reset();
    set_ds_rdy(1'b0);
    for (int k = 0; k < 6; k++) send_q.push_back(64'h100 + 64'(k));
    repeat (8) @(negedge clk);
    check("bp_accept_count", 64'(accept_cnt), 4);
    check("bp_rdy_low", 64'(nn_cmd_rdy_o), 0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp_hold_vld", 64'(ds_vld), 1);
      check("bp_hold_id", 64'(ds_id), 0);
      check("bp_hold_data", ds_data, 64'h100);
    end
    set_ds_rdy(1'b1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("bp_release_vld", 64'(ds_vld), 1);
      check("bp_release_id", 64'(ds_id), 64'(k));
    end

    // Outstanding limit
    do_reset();
    base = issue_cnt;
    for (int k = 0; k < 10; k++) send_q.push_back(64'h200 + 64'(k));
    repeat (20) @(negedge clk);
    check("lim_outstanding", 64'(outstanding), 8);
    check("lim_vld_low", 64'(ds_vld), 0);
    check("lim_issue_count", 64'(issue_cnt - base), 8);
    done_q.push_back(4'd0);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (done_i) seen = 1'b1;
    end
    check("lim_done_seen", 64'(seen), 1);
    @(negedge clk);
    check("lim_resume_vld", 64'(ds_vld), 1);
    check("lim_resume_id", 64'(ds_id), 8);
    check("lim_resume_data", ds_data, 64'h208);

    // ID wrap with prompt completions
    do_reset();
    auto_done = 1'b1;
    base = issue_cnt;
    for (int k = 0; k < 20; k++) send_q.push_back(64'h300 + 64'(k));
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (send_q.size() == 0 && exp_q.size() == 0 && done_q.size() == 0 && idle) seen = 1'b1;
    end
    check("wrap_drained", 64'(seen), 1);
    check("wrap_issue_count", 64'(issue_cnt - base), 20);
    check("wrap_err", 64'(err), 0);
    check("wrap_outstanding", 64'(outstanding), 0);
    auto_done = 1'b0;

    // Wrong-ID completion
    do_reset();
    send_q.push_back(64'h400);
    repeat (5) @(negedge clk);
    check("badid_outstanding_before", 64'(outstanding), 1);
    done_q.push_back(4'd3);
    repeat (4) @(negedge clk);
    check("badid_err", 64'(err), 1);
    check("badid_outstanding_after", 64'(outstanding), 0);

    // Spurious completion while idle, then sticky until reset
    do_reset();
    @(negedge clk);
    check("spur_err_cleared", 64'(err), 0);
    done_q.push_back(4'd5);
    repeat (4) @(negedge clk);
    check("spur_err", 64'(err), 1);
    check("spur_outstanding", 64'(outstanding), 0);
    repeat (10) @(negedge clk);
    check("spur_err_sticky", 64'(err), 1);

    // Reset mid-stream with buffered and outstanding commands
    do_reset();
    for (int k = 0; k < 5; k++) send_q.push_back(64'h500 + 64'(k));
    repeat (10) @(negedge clk);
    check("mid_outstanding5", 64'(outstanding), 5);
    set_ds_rdy(1'b0);
    for (int k = 0; k < 3; k++) send_q.push_back(64'h600 + 64'(k));
    repeat (6) @(negedge clk);
    check("mid_idle_low", 64'(idle), 0);
    do_reset();
    @(negedge clk);
    check_reset_values(1'b0);
    set_ds_rdy(1'b1);
    send_q.push_back(64'h77);
    repeat (5) @(negedge clk);
    check("mid_after_outstanding", 64'(outstanding), 1);
    check("mid_after_err", 64'(err), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
